// File: rtl/rv32i_mem_responder.sv
// ============================================================================
// rv32i_mem_responder
// ----------------------------------------------------------------------------
// Memory-side responder for the RV32I multicycle core's memory interface.
// A word-addressed register array with byte-enable writes and a fixed response
// latency. The core holds mem_read/mem_write/address/data until mem_resp; the
// request is captured once in IDLE and never re-sampled until the transaction
// has fully retired (RESP then RECOVER).
//
// Parameters:
//   DEPTH_WORDS  number of 32-bit words (power of two, 2..4096)
//   LATENCY      edges from request capture to the edge that raises mem_resp
//                (1..15)
//
// Ports:
//   clk              clock, rising edge
//   rst              asynchronous active-high reset
//   mem_read         read request level
//   mem_write        write request level
//   mem_byte_enable  per-byte write enable, bit i -> bits [8i+7:8i]
//   mem_address      byte address; [1:0] and bits above the index ignored
//   mem_wdata        write data
//   mem_resp         one-cycle completion pulse
//   mem_rdata        read data; holds last read value
//   busy             high whenever the FSM is not IDLE
//   err              sticky: read and write requested together
//   txn_count        completed transactions, wraps modulo 2^16
// ============================================================================
module rv32i_mem_responder #(
    parameter int DEPTH_WORDS = 256,
    parameter int LATENCY     = 4
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        mem_read,
    input  logic        mem_write,
    input  logic [3:0]  mem_byte_enable,
    input  logic [31:0] mem_address,
    input  logic [31:0] mem_wdata,
    output logic        mem_resp,
    output logic [31:0] mem_rdata,
    output logic        busy,
    output logic        err,
    output logic [15:0] txn_count
);

    localparam int IDX_W = $clog2(DEPTH_WORDS);

    typedef enum logic [1:0] {
        IDLE,
        BUSY,
        RESP,
        RECOVER
    } state_t;

    state_t             state;
    state_t             next_state;
    logic               capture;
    logic               commit;
    logic [3:0]         cnt;
    logic [IDX_W-1:0]   idx_q;
    logic               write_q;
    logic [31:0]        wdata_q;
    logic [3:0]         be_q;
    logic [31:0]        mem [DEPTH_WORDS];

    // Address bits outside the word index are deliberately ignored (aliasing).
    logic unused_addr_bits;
    assign unused_addr_bits = ^{mem_address[31:IDX_W+2], mem_address[1:0]};

    // ------------------------------------------------------------------
    // FSM state register
    // ------------------------------------------------------------------
    // NOTE: sequential state always uses non-blocking (<=) so every flop
    // samples pre-edge values regardless of block ordering.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state <= IDLE;
        end else begin
            state <= next_state;
        end
    end

    // ------------------------------------------------------------------
    // Next-state logic; capture/commit mark the IDLE->BUSY and BUSY->RESP
    // edges for the datapath.
    // ------------------------------------------------------------------
    always_comb begin
        // NOTE: every output of this block gets a default first, so no path
        // leaves a variable unassigned and no latch is inferred.
        next_state = state;
        capture    = 1'b0;
        commit     = 1'b0;
        case (state)
            IDLE: begin
                if (mem_read || mem_write) begin
                    capture    = 1'b1;
                    next_state = BUSY;
                end
            end
            BUSY: begin
                if (cnt == 4'd0) begin
                    commit     = 1'b1;
                    next_state = RESP;
                end
            end
            RESP:    next_state = RECOVER;
            // RECOVER ignores inputs so a still-held request cannot retrigger.
            RECOVER: next_state = IDLE;
            default: next_state = IDLE;
        endcase
    end

    // ------------------------------------------------------------------
    // Request capture, latency counter, read data, error and counter.
    // ------------------------------------------------------------------
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            cnt       <= '0;
            idx_q     <= '0;
            write_q   <= 1'b0;
            wdata_q   <= '0;
            be_q      <= '0;
            mem_rdata <= '0;
            err       <= 1'b0;
            txn_count <= '0;
        end else begin
            if (capture) begin
                idx_q   <= mem_address[IDX_W+1:2];
                // Read+write together resolves to a write.
                write_q <= mem_write;
                wdata_q <= mem_wdata;
                be_q    <= mem_byte_enable;
                cnt     <= 4'(LATENCY - 1);
                if (mem_read && mem_write) begin
                    err <= 1'b1;
                end
            end else if (state == BUSY && cnt != 4'd0) begin
                cnt <= cnt - 4'd1;
            end

            if (commit) begin
                txn_count <= txn_count + 16'd1;
                if (!write_q) begin
                    mem_rdata <= mem[idx_q];
                end
            end
        end
    end

    // ------------------------------------------------------------------
    // Storage array. Byte-granular commit on the edge entering RESP; a
    // transaction aborted by reset never reaches commit, so nothing lands.
    // ------------------------------------------------------------------
    // NOTE: the array must read as zero after reset, so it is built from
    // resettable flops rather than an inferred RAM (RAM macros cannot be
    // cleared in one cycle).
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            for (int w = 0; w < DEPTH_WORDS; w++) begin
                mem[w] <= '0;
            end
        end else if (commit && write_q) begin
            for (int b = 0; b < 4; b++) begin
                if (be_q[b]) begin
                    mem[idx_q][8*b +: 8] <= wdata_q[8*b +: 8];
                end
            end
        end
    end

    assign mem_resp = (state == RESP);
    assign busy     = (state != IDLE);

endmodule

// File: tb/tb_rv32i_mem_responder.sv
// ============================================================================
// tb_rv32i_mem_responder
// ----------------------------------------------------------------------------
// Self-checking bench for rv32i_mem_responder (DEPTH_WORDS=256, LATENCY=4).
// A table of single transactions with hand-computed read data, followed by
// hand-written sequences for held requests, early-dropped requests,
// simultaneous read+write and asynchronous reset mid-transaction.
// ============================================================================
module tb_rv32i_mem_responder;

    localparam int DEPTH_WORDS = 256;
    localparam int LATENCY     = 4;
    localparam int MAX_WAIT    = 40;
    localparam int N_VEC       = 11;

    logic        clk = 1'b0;
    logic        rst;
    logic        mem_read;
    logic        mem_write;
    logic [3:0]  mem_byte_enable;
    logic [31:0] mem_address;
    logic [31:0] mem_wdata;
    logic        mem_resp;
    logic [31:0] mem_rdata;
    logic        busy;
    logic        err;
    logic [15:0] txn_count;

    int n_checks = 0;
    int n_fail   = 0;

    rv32i_mem_responder #(
        .DEPTH_WORDS(DEPTH_WORDS),
        .LATENCY    (LATENCY)
    ) dut (
        .clk            (clk),
        .rst            (rst),
        .mem_read       (mem_read),
        .mem_write      (mem_write),
        .mem_byte_enable(mem_byte_enable),
        .mem_address    (mem_address),
        .mem_wdata      (mem_wdata),
        .mem_resp       (mem_resp),
        .mem_rdata      (mem_rdata),
        .busy           (busy),
        .err            (err),
        .txn_count      (txn_count)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic        rd;
        logic        wr;
        logic [31:0] addr;
        logic [31:0] wdata;
        logic [3:0]  be;
        logic [31:0] exp_rdata;   // mem_rdata expected in the RESP cycle
    } vec_t;

    vec_t vecs [N_VEC];

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%08h expected 0x%08h", name, act, exp);
        end
    endtask

    // Waits for mem_resp, counting edges since capture (start = edges already
    // seen). Returns MAX_WAIT+ on timeout so the latency check fails.
    task automatic wait_resp(input int start, output int edges, output logic [31:0] rd);
        edges = start;
        rd    = 'x;
        while (edges < MAX_WAIT) begin
            @(posedge clk);
            #1;
            edges++;
            if (mem_resp) begin
                rd = mem_rdata;
                break;
            end
        end
    endtask

    // Full transaction: drive, capture, wait for resp, drop, retire to IDLE.
    task automatic run_txn(input logic rd, input logic wr, input logic [31:0] addr,
                           input logic [31:0] wdata, input logic [3:0] be,
                           output int edges, output logic [31:0] rdata);
        @(negedge clk);
        mem_read        = rd;
        mem_write       = wr;
        mem_address     = addr;
        mem_wdata       = wdata;
        mem_byte_enable = be;
        @(posedge clk);              // capture edge
        wait_resp(0, edges, rdata);
        mem_read  = 1'b0;
        mem_write = 1'b0;
        @(posedge clk); #1;          // RECOVER
        @(posedge clk); #1;          // IDLE
    endtask

    initial begin
        int          edges;
        int          pulses;
        logic [31:0] rdata;

        // addr, data, be, expected mem_rdata in RESP (writes keep last read)
        vecs[0]  = '{1'b1, 1'b0, 32'h0000_0010, 32'h0,         4'h0,    32'h0000_0000};
        vecs[1]  = '{1'b0, 1'b1, 32'h0000_0020, 32'hDEADBEEF,  4'hF,    32'h0000_0000};
        vecs[2]  = '{1'b1, 1'b0, 32'h0000_0020, 32'h0,         4'h0,    32'hDEADBEEF};
        vecs[3]  = '{1'b0, 1'b1, 32'h0000_0040, 32'h11223344,  4'hF,    32'hDEADBEEF};
        vecs[4]  = '{1'b0, 1'b1, 32'h0000_0040, 32'hAABBCCDD,  4'b0101, 32'hDEADBEEF};
        vecs[5]  = '{1'b1, 1'b0, 32'h0000_0040, 32'h0,         4'h0,    32'h11BB33DD};
        vecs[6]  = '{1'b0, 1'b1, 32'h0000_0403, 32'hCAFEF00D,  4'hF,    32'h11BB33DD};
        vecs[7]  = '{1'b1, 1'b0, 32'h0000_0000, 32'h0,         4'h0,    32'hCAFEF00D};
        vecs[8]  = '{1'b0, 1'b1, 32'h0000_0044, 32'hFFFFFFFF,  4'h0,    32'hCAFEF00D};
        vecs[9]  = '{1'b1, 1'b0, 32'h0000_0044, 32'h0,         4'h0,    32'h0000_0000};
        vecs[10] = '{1'b1, 1'b0, 32'h0000_0020, 32'h0,         4'h0,    32'hDEADBEEF};

        rst             = 1'b1;
        mem_read        = 1'b0;
        mem_write       = 1'b0;
        mem_byte_enable = 4'h0;
        mem_address     = 32'h0;
        mem_wdata       = 32'h0;

        #12;
        check("reset_resp",  32'(mem_resp),  32'h0);
        check("reset_rdata", mem_rdata,      32'h0);
        check("reset_busy",  32'(busy),      32'h0);
        check("reset_err",   32'(err),       32'h0);
        check("reset_txn",   32'(txn_count), 32'h0);
        @(negedge clk);
        rst = 1'b0;

        // ---------------- table-driven transactions ----------------
        for (int i = 0; i < N_VEC; i++) begin
            run_txn(vecs[i].rd, vecs[i].wr, vecs[i].addr, vecs[i].wdata, vecs[i].be, edges, rdata);
            check($sformatf("v%0d_latency", i), 32'(edges), 32'(LATENCY));
            check($sformatf("v%0d_rdata", i), rdata, vecs[i].exp_rdata);
            check($sformatf("v%0d_txn", i), 32'(txn_count), 32'(i + 1));
            check($sformatf("v%0d_idle", i), 32'(busy), 32'h0);
        end
        check("table_err", 32'(err), 32'h0);

        // ---------------- read held through RESP and RECOVER ----------------
        @(negedge clk);
        mem_read    = 1'b1;
        mem_address = 32'h0000_0020;
        @(posedge clk);                          // capture
        pulses = 0;
        for (int k = 1; k <= LATENCY + 1; k++) begin
            @(posedge clk); #1;
            if (mem_resp) pulses++;
            if (k == LATENCY) check("held_rdata", mem_rdata, 32'hDEADBEEF);
        end
        check("held_recover_busy", 32'(busy), 32'h1);
        @(negedge clk);
        mem_read = 1'b0;                         // dropped during RECOVER
        for (int k = 0; k < 4; k++) begin
            @(posedge clk); #1;
            if (mem_resp) pulses++;
        end
        check("held_pulses", 32'(pulses), 32'h1);
        check("held_idle", 32'(busy), 32'h0);
        check("held_txn", 32'(txn_count), 32'd12);

        // ---------------- read dropped after one BUSY cycle ----------------
        @(negedge clk);
        mem_read    = 1'b1;
        mem_address = 32'h0000_0040;
        @(posedge clk);                          // capture
        @(posedge clk);                          // first BUSY edge
        @(negedge clk);
        mem_read    = 1'b0;
        mem_address = 32'h0000_0020;             // must not be re-sampled
        wait_resp(1, edges, rdata);
        check("drop_latency", 32'(edges), 32'(LATENCY));
        check("drop_rdata", rdata, 32'h11BB33DD);
        @(posedge clk); #1;
        @(posedge clk); #1;
        check("drop_txn", 32'(txn_count), 32'd13);

        // ---------------- read and write together ----------------
        run_txn(1'b1, 1'b1, 32'h0000_0048, 32'h5A5A5A5A, 4'hF, edges, rdata);
        check("rw_latency", 32'(edges), 32'(LATENCY));
        check("rw_rdata_kept", rdata, 32'h11BB33DD);
        check("rw_err", 32'(err), 32'h1);
        run_txn(1'b1, 1'b0, 32'h0000_0048, 32'h0, 4'h0, edges, rdata);
        check("rw_readback", rdata, 32'h5A5A5A5A);
        check("rw_err_sticky", 32'(err), 32'h1);
        check("rw_txn", 32'(txn_count), 32'd15);

        // ---------------- async reset during a BUSY write ----------------
        @(negedge clk);
        mem_write       = 1'b1;
        mem_address     = 32'h0000_0008;
        mem_wdata       = 32'h12345678;
        mem_byte_enable = 4'hF;
        @(posedge clk);                          // capture
        @(posedge clk);                          // in BUSY
        #3;
        rst = 1'b1;
        #1;
        check("arst_busy",  32'(busy),      32'h0);
        check("arst_resp",  32'(mem_resp),  32'h0);
        check("arst_err",   32'(err),       32'h0);
        check("arst_txn",   32'(txn_count), 32'h0);
        check("arst_rdata", mem_rdata,      32'h0);
        mem_write = 1'b0;
        @(negedge clk);
        rst = 1'b0;
        pulses = 0;
        for (int k = 0; k < LATENCY + 2; k++) begin
            @(posedge clk); #1;
            if (mem_resp) pulses++;
        end
        check("arst_no_pulse", 32'(pulses), 32'h0);
        run_txn(1'b1, 1'b0, 32'h0000_0008, 32'h0, 4'h0, edges, rdata);
        check("arst_read_latency", 32'(edges), 32'(LATENCY));
        check("arst_read_data", rdata, 32'h0);
        check("arst_read_txn", 32'(txn_count), 32'd1);
        run_txn(1'b1, 1'b0, 32'h0000_0020, 32'h0, 4'h0, edges, rdata);
        check("arst_array_cleared", rdata, 32'h0);

        $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog expired");
    end

endmodule
